// File: rtl/counter_timer_pkg.sv
// Shared types for the counter timer controller: FSM state codes and reload mode.
package counter_timer_pkg;

    typedef logic [2:0] timer_state_t;

    localparam timer_state_t IDLE  = 3'd0;
    localparam timer_state_t SETUP = 3'd1;
    localparam timer_state_t LOAD  = 3'd2;
    localparam timer_state_t RUN   = 3'd3;
    localparam timer_state_t DONE  = 3'd4;

    typedef enum logic {
        ONE_SHOT    = 1'b0,
        AUTO_RELOAD = 1'b1
    } mode_t;

endpackage

// File: rtl/counter_timer_controller_if.sv
// Control and external-counter signals of the counter timer controller.
// TIMER_EXPIRE_COUNT_EN adds the expire_count output.
interface counter_timer_controller_if #(
    parameter int unsigned SIZE           = 4,
    parameter int unsigned PRESCALE_WIDTH = 8
`ifdef TIMER_EXPIRE_COUNT_EN
    , parameter int unsigned EXPIRE_WIDTH = 8
`endif
);
    logic                      start;
    logic                      stop;
    logic                      pause;
    logic                      auto_reload;
    logic                      direction;
    logic [SIZE-1:0]           period;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      cnt_carry_out;
    logic                      cnt_reset;
    logic                      cnt_preset_en;
    logic                      cnt_up_down;
    logic                      cnt_carry_in;
    logic [SIZE-1:0]           cnt_preset;
    logic                      busy;
    logic                      expired;
    logic                      done;
`ifdef TIMER_EXPIRE_COUNT_EN
    logic [EXPIRE_WIDTH-1:0]   expire_count;
`endif

    modport slave (
`ifdef TIMER_EXPIRE_COUNT_EN
        output expire_count,
`endif
        input  start, stop, pause, auto_reload, direction, period, prescale, cnt_carry_out,
        output cnt_reset, cnt_preset_en, cnt_up_down, cnt_carry_in, cnt_preset,
        output busy, expired, done
    );

    modport master (
`ifdef TIMER_EXPIRE_COUNT_EN
        input  expire_count,
`endif
        output start, stop, pause, auto_reload, direction, period, prescale, cnt_carry_out,
        input  cnt_reset, cnt_preset_en, cnt_up_down, cnt_carry_in, cnt_preset,
        input  busy, expired, done
    );

endinterface

// File: rtl/tick_prescaler.sv
// Clock divider: o_tick fires once every i_prescale+1 non-held cycles; hold freezes the phase.
module tick_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_hold,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tick
);
    logic [PRESCALE_WIDTH-1:0] r_count;
    logic                      w_wrap;

    assign w_wrap = (r_count == i_prescale);
    assign o_tick = w_wrap & ~i_hold;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!i_hold) begin
            r_count <= w_wrap ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_timer_controller.sv
// Sequences an external presettable up/down counter as a one-shot or auto-reload interval timer.
// TIMER_EXPIRE_COUNT_EN adds a saturating count of expiries.
module counter_timer_controller
    import counter_timer_pkg::*;
#(
    parameter int unsigned SIZE           = 4,
    parameter int unsigned PRESCALE_WIDTH = 8
`ifdef TIMER_EXPIRE_COUNT_EN
    , parameter int unsigned EXPIRE_WIDTH = 8
`endif
) (
    input logic                 i_clock,
    input logic                 i_reset,
    counter_timer_controller_if.slave io_bus
);
    timer_state_t              r_state;
    timer_state_t              w_state_next;
    logic [SIZE-1:0]           r_period;
    logic                      r_direction;
    mode_t                     r_mode;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_pause_q;
    logic                      r_expired;

    logic w_accept;
    logic w_tick;
    logic w_terminal;
    logic w_presc_clear;
    logic w_presc_hold;

    assign w_accept      = ((r_state == IDLE) || (r_state == DONE)) & io_bus.start & ~io_bus.stop;
    assign w_presc_clear = (r_state == LOAD);
    assign w_presc_hold  = (r_state != RUN) | r_pause_q;
    assign w_terminal    = w_tick & ~io_bus.cnt_carry_out;

    tick_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_tick_prescaler (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_presc_clear),
        .i_hold    (w_presc_hold),
        .i_prescale(r_prescale),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_next = r_state;
        if (io_bus.stop) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: if (io_bus.start) w_state_next = SETUP;
                SETUP:      w_state_next = LOAD;
                LOAD:       w_state_next = RUN;
                RUN: begin
                    if (w_terminal) w_state_next = (r_mode == AUTO_RELOAD) ? LOAD : DONE;
                end
                default:    w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_period    <= '0;
            r_direction <= 1'b0;
            r_mode      <= ONE_SHOT;
            r_prescale  <= '0;
            r_pause_q   <= 1'b0;
            r_expired   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pause_q <= io_bus.pause;
            // A stop on the terminal cycle swallows the expiry.
            r_expired <= w_terminal & ~io_bus.stop;
            if (w_accept) begin
                r_period    <= io_bus.period;
                r_direction <= io_bus.direction;
                r_mode      <= io_bus.auto_reload ? AUTO_RELOAD : ONE_SHOT;
                r_prescale  <= io_bus.prescale;
            end
        end
    end

`ifdef TIMER_EXPIRE_COUNT_EN
    logic [EXPIRE_WIDTH-1:0] r_expire_count;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_expire_count <= '0;
        end else if (w_accept) begin
            r_expire_count <= '0;
        end else if (w_terminal && !io_bus.stop && (r_expire_count != '1)) begin
            r_expire_count <= r_expire_count + 1'b1;
        end
    end

    assign io_bus.expire_count = r_expire_count;
`endif

    assign io_bus.cnt_reset     = (r_state == IDLE);
    assign io_bus.cnt_preset_en = (r_state == LOAD);
    assign io_bus.cnt_up_down   = r_direction;
    assign io_bus.cnt_carry_in  = ~w_tick;
    assign io_bus.cnt_preset    = r_period;
    assign io_bus.busy          = (r_state == SETUP) || (r_state == LOAD) || (r_state == RUN);
    assign io_bus.expired       = r_expired;
    assign io_bus.done          = (r_state == DONE);

endmodule

// File: tb/tb_counter_timer_controller.sv
// Scoreboard bench for counter_timer_controller with a behavioural 4000-series counter model.
module tb_counter_timer_controller;
    localparam int unsigned SIZE = 4;
    localparam int unsigned PW   = 8;
    localparam int          SAT  = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    counter_timer_controller_if bus ();

    counter_timer_controller dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .io_bus (bus)
    );

    // External presettable up/down counter with active-low terminal count.
    logic [SIZE-1:0] ext_cnt = '0;
    always @(posedge clk) begin
        if (bus.cnt_reset === 1'b1)          ext_cnt <= '0;
        else if (bus.cnt_preset_en === 1'b1) ext_cnt <= bus.cnt_preset;
        else if (bus.cnt_carry_in === 1'b0)  ext_cnt <= bus.cnt_up_down ? ext_cnt + 1'b1
                                                                          : ext_cnt - 1'b1;
    end
    assign bus.cnt_carry_out = ~(bus.cnt_up_down ? (ext_cnt == '1) : (ext_cnt == '0));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int m_count  = 0;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    endtask

    function automatic int run_len(input bit up, input int per, input int presc);
        return (up ? ((1 << SIZE) - per) : (per + 1)) * (presc + 1);
    endfunction

    task automatic push_exp(input int c);
        m_count = (m_count < SAT) ? m_count + 1 : SAT;
        exp_q.push_back('{c, m_count});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    // Issues a start this cycle and predicts the first n expiry cycles.
    task automatic launch(input bit up, input int per, input int presc, input bit auto_rl,
                          input int n, input int delay, output int s, output int last);
        int len;
        s = cyc;
        bus.start       = 1'b1;
        bus.direction   = up;
        bus.period      = per[SIZE-1:0];
        bus.prescale    = presc[PW-1:0];
        bus.auto_reload = auto_rl;
        len     = run_len(up, per, presc);
        m_count = 0;
        for (int k = 0; k < n; k++) push_exp(s + 3 + delay + len + k * (len + 1));
        last = s + 3 + delay + len + (n - 1) * (len + 1);
        step();
        bus.start = 1'b0;
    endtask

    task automatic finish_run(input bit auto_rl, input int last);
        wait_to(last + 1);
        if (auto_rl) begin
            bus.stop = 1'b1;
            step();
            bus.stop = 1'b0;
        end
        wait_to(last + 3);
        chk("queue_drained", exp_q.size(), 0);
        chk("not_busy_after_run", bus.busy, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cnt_reset", bus.cnt_reset, 1);
        chk("rst_carry_in", bus.cnt_carry_in, 1);
        chk("rst_preset_en", bus.cnt_preset_en, 0);
        chk("rst_up_down", bus.cnt_up_down, 0);
        chk("rst_preset", bus.cnt_preset, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_expired", bus.expired, 0);
        chk("rst_done", bus.done, 0);
`ifdef TIMER_EXPIRE_COUNT_EN
        chk("rst_expire_count", bus.expire_count, 0);
`endif
    endtask

    // Monitor: every expired pulse must match the next predicted expiry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.expired === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_expired", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("expired_cycle", cyc, e.cyc);
`ifdef TIMER_EXPIRE_COUNT_EN
                    chk("expire_count", bus.expire_count, e.cnt);
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, last, s2, last2;
        bit up, ar;
        int per, presc, n;

        bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.auto_reload = 1'b0;
        bus.direction = 1'b0; bus.period = '0; bus.prescale = '0;
        repeat (3) step();
        chk_reset_vals();
        rst_n = 1'b1;
        step();

        // Down, period 3, prescale 0, one-shot.
        launch(1'b0, 3, 0, 1'b0, 1, 0, s, last);
        chk("setup_busy", bus.busy, 1);
        wait_to(s + 2);
        chk("load_preset_en", bus.cnt_preset_en, 1);
        chk("load_preset", bus.cnt_preset, 3);
        for (int c = s + 3; c <= s + 6; c++) begin
            wait_to(c);
            chk("down_carry_in", bus.cnt_carry_in, 0);
        end
        wait_to(s + 7);
        chk("down_carry_in_end", bus.cnt_carry_in, 1);
        chk("down_done", bus.done, 1);
        finish_run(1'b0, last);

        // Up, period 14, prescale 2, auto-reload: 7-cycle cadence.
        launch(1'b1, 14, 2, 1'b1, 3, 0, s, last);
        for (int c = s + 3; c <= last; c++) begin
            wait_to(c);
            chk("reload_carry_in", bus.cnt_carry_in,
                (((c - s - 3) % 7 == 2) || ((c - s - 3) % 7 == 5)) ? 0 : 1);
        end
        finish_run(1'b1, last);

        // Pause held 5 cycles mid-RUN delays expiry by 5 and keeps prescaler phase.
        launch(1'b0, 5, 1, 1'b0, 1, 5, s, last);
        wait_to(s + 5);
        bus.pause = 1'b1;
        for (int c = s + 6; c <= s + 10; c++) begin
            wait_to(c);
            if (c == s + 10) bus.pause = 1'b0;
            chk("pause_no_tick", bus.cnt_carry_in, 1);
        end
        wait_to(s + 11);
        chk("pause_phase_kept", bus.cnt_carry_in, 0);
        finish_run(1'b0, last);

        // Stop on the terminal tick cycle.
        launch(1'b0, 2, 0, 1'b0, 0, 0, s, last);
        wait_to(s + 5);
        chk("term_tick", bus.cnt_carry_in, 0);
        chk("term_carry_out", bus.cnt_carry_out, 0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("stop_cnt_reset", bus.cnt_reset, 1);
        chk("stop_busy", bus.busy, 0);
        chk("stop_carry_in", bus.cnt_carry_in, 1);
        chk("stop_expired", bus.expired, 0);
        repeat (2) step();

        // Start during RUN ignored; restart from DONE with period 0 down.
        launch(1'b0, 4, 0, 1'b0, 1, 0, s, last);
        wait_to(s + 4);
        bus.start = 1'b1; bus.period = '0; bus.direction = 1'b1;
        bus.prescale = 8'd7; bus.auto_reload = 1'b1;
        step();
        bus.start = 1'b0;
        wait_to(s + 9);
        chk("busy_start_done", bus.done, 1);
        chk("busy_start_preset", bus.cnt_preset, 4);
        launch(1'b0, 0, 0, 1'b0, 1, 0, s2, last2);
        chk("restart_done_clear", bus.done, 0);
        wait_to(s2 + 4);
        chk("restart_done", bus.done, 1);
        finish_run(1'b0, last2);

        // Reset low mid-run, just as another expiry would land.
        launch(1'b1, 15, 0, 1'b1, 3, 0, s, last);
        wait_to(s + 9);
        rst_n = 1'b0;
        step();
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (3) step();
        chk("reset_queue_drained", exp_q.size(), 0);

        // Long auto-reload run: expire_count saturates.
        launch(1'b1, 15, 0, 1'b1, 260, 0, s, last);
        finish_run(1'b1, last);

        // Randomised runs, with a stray start and input changes while busy.
        for (int i = 0; i < 15; i++) begin
            up    = 1'($urandom_range(0, 1));
            ar    = 1'($urandom_range(0, 1));
            per   = int'($urandom_range(0, 15));
            presc = int'($urandom_range(0, 3));
            n     = ar ? int'($urandom_range(1, 3)) : 1;
            launch(up, per, presc, ar, n, 0, s, last);
            bus.start = 1'b1;
            bus.period = 4'($urandom_range(0, 15));
            bus.direction = 1'($urandom_range(0, 1));
            bus.prescale = 8'($urandom_range(0, 255));
            step();
            bus.start = 1'b0;
            finish_run(ar, last);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
